spio_spinnaker_link_sym_tx: RTL

SPIO_SPINNAKER_LINK_SYM_TX -- requirements
Module: spio_spinnaker_link_sym_tx

---
 rtl/spio_spinnaker_link_sym_tx_if.sv | 37 +++
 rtl/spio_spinnaker_link_sym_tx.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/spio_spinnaker_link_sym_tx_if.sv
`default_nettype none
// ============================================================================
// Module : spio_spinnaker_link_sym_tx_if
// Desc   : Symbol-side handshake and 2-of-7 link wires of the symbol transmitter.
// Rev    : 1.0 - initial release
// ============================================================================
interface spio_spinnaker_link_sym_tx_if;
    logic [3:0] SYM_DATA_IN;
    logic       SYM_EOP_IN;
    logic       SYM_VLD_IN;
    logic       SYM_RDY_OUT;
    logic [6:0] L_DATA_OUT;
    logic       L_ACK_IN;
    logic       TIMEOUT_OUT;

    // master: the transmitter itself; slave: the symbol source plus far-end link
    modport master (
        input  SYM_DATA_IN,
        input  SYM_EOP_IN,
        input  SYM_VLD_IN,
        input  L_ACK_IN,
        output SYM_RDY_OUT,
        output L_DATA_OUT,
        output TIMEOUT_OUT
    );

    modport slave (
        output SYM_DATA_IN,
        output SYM_EOP_IN,
        output SYM_VLD_IN,
        output L_ACK_IN,
        input  SYM_RDY_OUT,
        input  L_DATA_OUT,
        input  TIMEOUT_OUT
    );
endinterface
`default_nettype wire

// File: rtl/spio_spinnaker_link_sym_tx.sv
`default_nettype none
// ============================================================================
// Module : spio_spinnaker_link_sym_tx
// Desc   : 2-of-7 NRZ symbol transmitter with synchronised ack and ack timeout.
// Rev    : 1.0 - initial release
// ============================================================================
module spio_spinnaker_link_sym_tx #(
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                          CLK_IN,
    input  logic                          RESET_IN,
    spio_spinnaker_link_sym_tx_if.master  lnk
);

    localparam int         c_CNT_W       = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam bit         c_TO_EN       = (ACK_TIMEOUT > 0);
    localparam logic [1:0] c_SETTLE_LAST = 2'd2;
    localparam logic [6:0] c_CODE_EOP    = 7'h60;

    typedef enum logic [1:0] {
        ST_SETTLE   = 2'd0,
        ST_IDLE     = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_settle_cnt;
    logic [1:0]         w_settle_cnt_nxt;
    logic               r_ack_meta;
    logic               r_ack_s;
    logic               r_ack_ref;
    logic               w_ack_ref_nxt;
    logic [6:0]         r_data;
    logic [6:0]         w_data_nxt;
    logic [6:0]         w_code;
    logic               r_rdy;
    logic               r_timeout;
    logic               w_timeout_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic               w_expire;

    // The raw ack is asynchronous; only r_ack_s is ever looked at.
    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            r_ack_meta <= 1'b0;
            r_ack_s    <= 1'b0;
        end else begin
            r_ack_meta <= lnk.L_ACK_IN;
            r_ack_s    <= r_ack_meta;
        end
    end

    always_comb begin
        w_code = 7'h11;
        if (lnk.SYM_EOP_IN) begin
            w_code = c_CODE_EOP;
        end else begin
            case (lnk.SYM_DATA_IN)
                4'h0:    w_code = 7'h11;
                4'h1:    w_code = 7'h12;
                4'h2:    w_code = 7'h14;
                4'h3:    w_code = 7'h18;
                4'h4:    w_code = 7'h21;
                4'h5:    w_code = 7'h22;
                4'h6:    w_code = 7'h24;
                4'h7:    w_code = 7'h28;
                4'h8:    w_code = 7'h41;
                4'h9:    w_code = 7'h42;
                4'hA:    w_code = 7'h44;
                4'hB:    w_code = 7'h48;
                4'hC:    w_code = 7'h03;
                4'hD:    w_code = 7'h06;
                4'hE:    w_code = 7'h0C;
                default: w_code = 7'h09;
            endcase
        end
    end

    assign w_cnt_inc = r_cnt + c_CNT_W'(1);

    generate
        if (ACK_TIMEOUT > 0) begin : g_timeout
            localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(ACK_TIMEOUT);
            assign w_expire = (w_cnt_inc == c_LIMIT);
        end else begin : g_no_timeout
            assign w_expire = 1'b0;
        end
    endgenerate

    always_comb begin
        w_state_nxt      = r_state;
        w_settle_cnt_nxt = r_settle_cnt;
        w_ack_ref_nxt    = r_ack_ref;
        w_data_nxt       = r_data;
        w_cnt_nxt        = r_cnt;
        w_timeout_nxt    = 1'b0;
        case (r_state)
            ST_SETTLE: begin
                if (r_settle_cnt == c_SETTLE_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_settle_cnt_nxt = r_settle_cnt + 2'd1;
                end
            end
            ST_IDLE: begin
                // Tracking the ack here swallows any stray toggles between symbols.
                w_ack_ref_nxt = r_ack_s;
                if (lnk.SYM_VLD_IN && r_rdy) begin
                    w_data_nxt  = r_data ^ w_code;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                // Ack is tested before expiry so a coincident ack suppresses the pulse.
                if (r_ack_s != r_ack_ref) begin
                    w_ack_ref_nxt = r_ack_s;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = ST_IDLE;
                end else if (w_expire) begin
                    w_timeout_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                end else if (c_TO_EN) begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt      = ST_SETTLE;
                w_settle_cnt_nxt = 2'd0;
            end
        endcase
    end

    always_ff @(posedge CLK_IN) begin
        if (RESET_IN) begin
            r_state      <= ST_SETTLE;
            r_settle_cnt <= 2'd0;
            r_ack_ref    <= 1'b0;
            r_data       <= 7'h00;
            r_cnt        <= '0;
            r_rdy        <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_settle_cnt <= w_settle_cnt_nxt;
            r_ack_ref    <= w_ack_ref_nxt;
            r_data       <= w_data_nxt;
            r_cnt        <= w_cnt_nxt;
            r_rdy        <= (w_state_nxt == ST_IDLE);
            r_timeout    <= w_timeout_nxt;
        end
    end

    assign lnk.SYM_RDY_OUT = r_rdy;
    assign lnk.L_DATA_OUT  = r_data;
    assign lnk.TIMEOUT_OUT = r_timeout;

endmodule
`default_nettype wire
